// File: rtl/data_unpacker.sv
// data_unpacker: splits packed N-lane vectors into beats of L lanes chosen by a per-chain firmware mode table
// Optional beat_count statistics output enabled by defining DATA_UNPACKER_STATS_EN
module data_unpacker #(
    parameter int N = 8,
    parameter int M = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tracing,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    input  logic [$clog2(N+1)-1:0]        lanes_in,
    input  logic                          eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(N+1)-1:0]        length_out,
    output logic                          valid_out,
    output logic                          eof_out,
    input  logic                          ready_in
`ifdef DATA_UNPACKER_STATS_EN
    ,
    output logic [31:0]                   beat_count
`endif
);
    localparam int LW = $clog2(N+1);
    localparam logic [LW-1:0] LN = LW'(N);
    localparam logic [LW-1:0] LM = LW'(M);
    localparam logic [LW-1:0] L1 = LW'(1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  r_state;
    logic [7:0]              r_fw [MAX_CHAINS];
    logic [N*DATA_WIDTH-1:0] r_rem;
    logic [N*DATA_WIDTH-1:0] r_vout;
    logic [LW-1:0]           r_left;
    logic [LW-1:0]           r_L;
    logic [LW-1:0]           r_len;
    logic                    r_eof;
    logic                    r_valid;
    logic                    r_eofout;

    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic                    w_last;
    logic [7:0]              w_mode;
    logic [LW-1:0]           w_L;
    logic [N*DATA_WIDTH-1:0] w_shift;
    logic [N*DATA_WIDTH-1:0] w_src_vec;
    logic [LW-1:0]           w_src_left;
    logic [LW-1:0]           w_src_L;
    logic [LW-1:0]           w_len;
    logic                    w_src_last;
    logic [N*DATA_WIDTH-1:0] w_vout;

    assign w_last     = r_valid && (r_left <= r_L);
    assign ready_out  = (r_state == IDLE) || (w_last && ready_in);
    assign w_in_xfer  = valid_in && ready_out && tracing;
    assign w_out_xfer = r_valid && ready_in;
    assign w_mode     = r_fw[chainId_in];
    assign w_L        = (w_mode == 8'd0) ? LN : (w_mode == 8'd1) ? LM : L1;
    assign w_shift    = (r_L == LN) ? '0 : (r_L == LM) ? (r_rem >> (M*DATA_WIDTH)) : (r_rem >> DATA_WIDTH);
    assign w_src_vec  = w_in_xfer ? vector_in : w_shift;
    assign w_src_left = w_in_xfer ? lanes_in : r_left - r_L;
    assign w_src_L    = w_in_xfer ? w_L : r_L;
    assign w_len      = (w_src_left < w_src_L) ? w_src_left : w_src_L;
    assign w_src_last = w_src_left <= w_src_L;

    assign vector_out = r_vout;
    assign length_out = r_len;
    assign valid_out  = r_valid;
    assign eof_out    = r_eofout;

    // next beat payload: lanes below the beat length pass, the rest are zeroed
    always_comb begin
        w_vout = '0;
        for (int j = 0; j < N; j++)
            w_vout[j*DATA_WIDTH +: DATA_WIDTH] = (LW'(j) < w_len) ? w_src_vec[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    // firmware shift register, vector latch and beat emission state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_eofout <= 1'b0;
            r_len    <= '0;
            r_vout   <= '0;
            r_rem    <= '0;
            r_left   <= '0;
            r_L      <= '0;
            r_eof    <= 1'b0;
            for (int i = 0; i < MAX_CHAINS; i++)
                r_fw[i] <= INITIAL_FIRMWARE[i*8 +: 8];
        end else begin
            if (configId == 8'(PERSONAL_CONFIG_ID)) begin
                for (int i = 0; i < MAX_CHAINS-1; i++)
                    r_fw[i] <= r_fw[i+1];
                r_fw[MAX_CHAINS-1] <= configData;
            end
            if (w_in_xfer || w_out_xfer) begin
                r_rem  <= w_src_vec;
                r_left <= w_src_left;
                r_L    <= w_src_L;
            end
            if (w_in_xfer)
                r_eof <= eof_in;
            if (w_in_xfer ? (lanes_in != '0 || eof_in) : (w_out_xfer && !w_last)) begin
                r_state  <= EMIT;
                r_valid  <= 1'b1;
                r_vout   <= w_vout;
                r_len    <= w_len;
                r_eofout <= (w_in_xfer ? eof_in : r_eof) && w_src_last;
            end else if (w_in_xfer || w_out_xfer) begin
                r_state  <= IDLE;
                r_valid  <= 1'b0;
                r_vout   <= '0;
                r_len    <= '0;
                r_eofout <= 1'b0;
            end
        end
    end

`ifdef DATA_UNPACKER_STATS_EN
    logic [31:0] r_beat_count;

    assign beat_count = r_beat_count;

    // free-running count of accepted output beats
    always_ff @(posedge clk) begin
        if (reset)
            r_beat_count <= '0;
        else if (w_out_xfer)
            r_beat_count <= r_beat_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_data_unpacker.sv
// tb_data_unpacker: scoreboard bench for data_unpacker with directed vectors
module tb_data_unpacker;
    localparam int N  = 8;
    localparam int M  = 2;
    localparam int DW = 32;
    localparam int VW = N*DW;
    localparam int XW = VW+8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tracing = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [VW-1:0] vector_in = '0;
    logic [3:0]    lanes_in = '0;
    logic          eof_in = 1'b0;
    logic [1:0]    chainId_in = '0;
    logic [7:0]    configId = 8'd0;
    logic [7:0]    configData = 8'd0;
    logic [VW-1:0] vector_out;
    logic [3:0]    length_out;
    logic          valid_out;
    logic          eof_out;
    logic          ready_in = 1'b1;
`ifdef DATA_UNPACKER_STATS_EN
    logic [31:0]   beat_count;
`endif

    data_unpacker #(
        .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(4),
        .PERSONAL_CONFIG_ID(5), .INITIAL_FIRMWARE(32'h02000100)
    ) dut (
        .clk(clk), .reset(reset), .tracing(tracing),
        .valid_in(valid_in), .ready_out(ready_out),
        .vector_in(vector_in), .lanes_in(lanes_in), .eof_in(eof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData),
        .vector_out(vector_out), .length_out(length_out), .valid_out(valid_out), .eof_out(eof_out),
        .ready_in(ready_in)
`ifdef DATA_UNPACKER_STATS_EN
        , .beat_count(beat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VW-1:0] v;
        logic [3:0]    len;
        logic          eof;
    } beat_t;

    beat_t   q[$];
    int      n_chk = 0;
    int      n_fail = 0;
    logic    prev_stall = 1'b0;
    logic [XW-1:0] prev = '0;

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input int base);
        logic [VW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(base + j);
        return v;
    endfunction

    task automatic push_exp(input logic [VW-1:0] v, input int lanes, input int L, input bit eof);
        beat_t b;
        int    len;
        if (lanes == 0) begin
            if (eof) begin
                b.v = '0; b.len = 4'd0; b.eof = 1'b1;
                q.push_back(b);
            end
            return;
        end
        for (int k = 0; k*L < lanes; k++) begin
            len = (lanes - k*L < L) ? lanes - k*L : L;
            b.v = '0;
            for (int j = 0; j < len; j++) b.v[j*DW +: DW] = v[(k*L+j)*DW +: DW];
            b.len = 4'(len);
            b.eof = eof && ((k+1)*L >= lanes);
            q.push_back(b);
        end
    endtask

    task automatic send(input logic [VW-1:0] v, input int lanes, input bit eof, input int ch);
        bit ok;
        int t = 0;
        vector_in = v; lanes_in = 4'(lanes); eof_in = eof; chainId_in = 2'(ch); valid_in = 1'b1;
        do begin
            @(negedge clk);
            ok = ready_out && tracing;
            @(posedge clk); #1;
            t++;
        end while (!ok && t < 100);
        valid_in = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: ready_out low for %0d cycles, required high", t);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_pending", XW'(q.size()), '0);
    endtask

    // monitor: pops the scoreboard on each output transfer and checks stall stability
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", XW'(valid_out), XW'(1));
                chk("hold_data", XW'({vector_out, length_out, eof_out}), prev);
            end
            if (valid_out && ready_in) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got len %0d eof %0d, required no beat", length_out, eof_out);
                end else begin
                    b = q.pop_front();
                    chk("beat_vec", XW'(vector_out), XW'(b.v));
                    chk("beat_len", XW'(length_out), XW'(b.len));
                    chk("beat_eof", XW'(eof_out), XW'(b.eof));
                end
            end
            prev_stall = valid_out && !ready_in;
            prev = XW'({vector_out, length_out, eof_out});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        int cnt;
        int g;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", XW'(valid_out), '0);
        chk("rst_eof", XW'(eof_out), '0);
        chk("rst_len", XW'(length_out), '0);
        chk("rst_vec", XW'(vector_out), '0);
        chk("rst_ready", XW'(ready_out), XW'(1));

        v = mkvec(1);
        push_exp(v, 8, 8, 0);
        send(v, 8, 0, 0);
        chk("latency_valid", XW'(valid_out), XW'(1));
        chk("latency_len", XW'(length_out), XW'(8));
        drain();

        push_exp(v, 8, 2, 0);
        send(v, 8, 0, 1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready_out) break;
            cnt++;
        end
        chk("ready_low_cycles", XW'(cnt), XW'(3));
        drain();

        push_exp(mkvec(16), 4, 2, 0);
        push_exp(mkvec(32), 4, 2, 1);
        send(mkvec(16), 4, 0, 1);
        g = 0;
        fork
            send(mkvec(32), 4, 1, 1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    if (!valid_out) g++;
                end
            end
        join
        chk("b2b_bubbles", XW'(g), '0);
        drain();

        push_exp(v, 3, 1, 1);
        fork
            send(v, 3, 1, 3);
            begin
                repeat (12) begin
                    @(posedge clk); #1;
                    ready_in = ~ready_in;
                end
                ready_in = 1'b1;
            end
        join
        drain();

        push_exp(mkvec(9), 3, 2, 1);
        send(mkvec(9), 3, 1, 1);
        drain();

        push_exp(mkvec(5), 0, 8, 1);
        send(mkvec(5), 0, 1, 0);
        send(mkvec(6), 0, 0, 0);
        drain();

        tracing = 1'b0;
        vector_in = mkvec(7); lanes_in = 4'd8; eof_in = 1'b0; chainId_in = 2'd0; valid_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 valid_in = 1'b0;
        tracing = 1'b1;
        drain();

        push_exp(v, 8, 2, 0);
        send(v, 8, 0, 1);
        tracing = 1'b0;
        drain();
        tracing = 1'b1;

        push_exp(v, 8, 2, 0);
        send(v, 8, 0, 1);
        configId = 8'd4; configData = 8'd0;
        @(posedge clk); #1;
        configId = 8'd5; configData = 8'd1;
        @(posedge clk); #1;
        configId = 8'd0;
        drain();
        push_exp(mkvec(40), 2, 1, 0);
        send(mkvec(40), 2, 0, 2);
        push_exp(mkvec(50), 4, 2, 1);
        send(mkvec(50), 4, 1, 3);
        drain();

        push_exp(v, 4, 2, 0);
        send(v, 8, 0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_valid", XW'(valid_out), '0);
        chk("rst_mid_ready", XW'(ready_out), XW'(1));
        drain();

        push_exp(v, 8, 2, 0);
        send(v, 8, 0, 1);
        push_exp(mkvec(3), 2, 1, 1);
        send(mkvec(3), 2, 1, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
